instr_encoder: RTL

Streaming RV32I instruction encoder and instruction-memory loader: the inverse of the core's decode path. It accepts field-level instruction descriptions (format, opcode, funct3, funct7b5, registers, immediate) over a valid/ready handshake. It packs each one into a 32-bit instruction word and writes it into consecutive instruction-memory words through a write port. It sits beside the single-cycle core's instruction memory and is used for boot/program loading and self-test program generation.

---
 rtl/instr_encoder_pkg.sv | 36 +++
 rtl/instr_encoder_pack.sv | 69 ++++++
 rtl/instr_encoder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: format enum, opcode constants, FSM states.
// The format encoding matches the core's ImmSrc encoding so descriptors can be reused verbatim.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_J = 3'b011,
        FMT_U = 3'b100,
        FMT_R = 3'b101
    } fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    // Shift-immediates (slli/srli/srai) carry a 5-bit shamt plus instruction bit 30.
    function automatic logic is_shift_imm(input logic [6:0] op, input logic [2:0] funct3);
        return (op == OPC_OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational field -> 32-bit RV32I word packer with illegal flag; zero latency, no handshake.
// INSTR_ENC_RANGE_CHECK_EN adds immediate range checks; otherwise immediates are truncated to the encoded bits.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic fmt_bad;
    logic range_ok;
    logic shift_imm;

    assign shift_imm = is_shift_imm(op, funct3);

    always_comb begin
        word    = 32'h0000_0000;
        fmt_bad = 1'b0;
        case (fmt_e'(fmt))
            FMT_R: word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, op};
            FMT_I: begin
                if (shift_imm) begin
                    word = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, op};
                end else begin
                    word = {imm[11:0], rs1, funct3, rd, op};
                end
            end
            FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
            FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
            FMT_U: word = {imm[31:12], rd, op};
            FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: fmt_bad = 1'b1;
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // A value fits in N signed bits when bits 31:N-1 are all copies of the sign.
    always_comb begin
        range_ok = 1'b1;
        case (fmt_e'(fmt))
            FMT_I: begin
                if (shift_imm) begin
                    range_ok = ~|imm[31:5];
                end else begin
                    range_ok = (&imm[31:11]) | (~|imm[31:11]);
                end
            end
            FMT_S:   range_ok = (&imm[31:11]) | (~|imm[31:11]);
            FMT_B:   range_ok = ((&imm[31:12]) | (~|imm[31:12])) & ~imm[0];
            FMT_J:   range_ok = ((&imm[31:20]) | (~|imm[31:20])) & ~imm[0];
            FMT_U:   range_ok = ~|imm[11:0];
            default: range_ok = 1'b1;
        endcase
    end
`else
    assign range_ok = 1'b1;
`endif

    assign illegal = fmt_bad | ~range_ok;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams field-level RV32I descriptors into consecutive instruction-memory words.
// Latency: accept at edge N -> we/waddr/wdata valid in cycle N+1; one descriptor per cycle.
// Backpressure: in_ready high only in LOAD. Optional INSTR_ENC_RANGE_CHECK_EN (inside instr_pack).
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_fmt,
    input  logic [6:0]    in_op,
    input  logic [2:0]    in_funct3,
    input  logic          in_funct7b5,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [31:0]   in_imm,
    input  logic          in_last,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [31:0]   wdata,
    output logic [AW:0]   count,
    output logic          done,
    output logic          full,
    output logic          err
);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;

    logic [31:0]   packed_word;
    logic          packed_illegal;
    logic          accept;
    logic          at_last_word;
    logic          restart;

    instr_pack u_pack (
        .fmt      (in_fmt),
        .op       (in_op),
        .funct3   (in_funct3),
        .funct7b5 (in_funct7b5),
        .rd       (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .imm      (in_imm),
        .word     (packed_word),
        .illegal  (packed_illegal)
    );

    assign accept       = in_valid & in_ready;
    assign at_last_word = (ptr_q == AW'(DEPTH - 1));
    assign restart      = start & (state_q != ST_LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (packed_illegal) begin
                        state_d = ST_ERR;
                    end else if (in_last || at_last_word) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // done waits for the final write to retire so a reader sees count complete.
    always_comb begin
        in_ready = (state_q == ST_LOAD);
        done     = (state_q == ST_DONE) & ~we_q;
    end

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q + {{AW{1'b0}}, we_q};
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        if (restart) begin
            ptr_d   = '0;
            count_d = '0;
            err_d   = 1'b0;
        end
        if (accept) begin
            if (packed_illegal) begin
                err_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                waddr_d = ptr_q;
                wdata_d = packed_word;
                ptr_d   = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign count = count_q;
    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign err   = err_q;

endmodule
